// File: rtl/ulpi_reg_access_if.sv
`default_nettype none
// ============================================================================
// ulpi_reg_access_if : request handshake and ULPI link-side bus bundle
// Revision: 1.0
// ============================================================================
interface ulpi_reg_access_if;
  logic       req;
  logic       rw;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       abort;
  logic [7:0] rdata;
  logic       DIR;
  logic       NXT;
  logic [7:0] DATA_in;
  logic [7:0] DATA_out;
  logic       DATA_oe;
  logic       STP;

  modport master (
    input  req, rw, addr, wdata, DIR, NXT, DATA_in,
    output busy, done, abort, rdata, DATA_out, DATA_oe, STP
  );

  modport slave (
    output req, rw, addr, wdata, DIR, NXT, DATA_in,
    input  busy, done, abort, rdata, DATA_out, DATA_oe, STP
  );
endinterface
`default_nettype wire

// File: rtl/ulpi_reg_access.sv
`default_nettype none
// ============================================================================
// ulpi_reg_access : ULPI link-side RegWrite/RegRead initiator (60MHz domain)
// Revision: 1.0
// ============================================================================
module ulpi_reg_access #(
  parameter int NXT_TIMEOUT = 64
) (
  input  logic              clk_ext,
  input  logic              rst,
  ulpi_reg_access_if.master bus
);

  localparam logic [7:0] TMO_LAST = 8'(NXT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BUS = 3'd1,
    S_CMD      = 3'd2,
    S_WDAT     = 3'd3,
    S_STOP     = 3'd4,
    S_RTA      = 3'd5,
    S_RDAT     = 3'd6,
    S_RTB      = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       rw_q, rw_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rbuf_q, rbuf_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       stp_q, stp_d;
  logic       go_abort;

  logic in_timed_state;
  logic timeout_hit;

  assign in_timed_state = (state_q == S_CMD) || (state_q == S_WDAT) ||
                          (state_q == S_RTA) || (state_q == S_RTB);
  assign timeout_hit    = (timer_q == TMO_LAST);

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      rdata_q    <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      stp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      rdata_q    <= rdata_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      stp_q      <= stp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    rdata_d    = rdata_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    stp_d      = 1'b0;
    go_abort   = 1'b0;
    timer_d    = '0;

    case (state_q)
      S_IDLE: begin
        // busy_q is only still high here during the done/abort pulse cycle
        busy_d     = 1'b0;
        data_oe_d  = 1'b0;
        data_out_d = '0;
        if (bus.req && !busy_q) begin
          rw_d    = bus.rw;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          busy_d  = 1'b1;
          if (!bus.DIR) begin
            state_d    = S_CMD;
            data_oe_d  = 1'b1;
            data_out_d = {1'b1, bus.rw, bus.addr};
          end else begin
            state_d = S_WAIT_BUS;
          end
        end
      end
      S_WAIT_BUS: begin
        if (!bus.DIR) begin
          state_d    = S_CMD;
          data_oe_d  = 1'b1;
          data_out_d = {1'b1, rw_q, addr_q};
        end
      end
      S_CMD: begin
        if (bus.DIR) begin
          go_abort = 1'b1;
        end else if (bus.NXT) begin
          if (rw_q) begin
            state_d    = S_RTA;
            data_oe_d  = 1'b0;
            data_out_d = '0;
          end else begin
            state_d    = S_WDAT;
            data_out_d = wdata_q;
          end
        end else if (timeout_hit) begin
          go_abort = 1'b1;
        end
      end
      S_WDAT: begin
        if (bus.DIR) begin
          go_abort = 1'b1;
        end else if (bus.NXT) begin
          state_d    = S_STOP;
          data_out_d = '0;
          stp_d      = 1'b1;
        end else if (timeout_hit) begin
          go_abort = 1'b1;
        end
      end
      S_STOP: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        data_oe_d = 1'b0;
      end
      S_RTA: begin
        if (bus.DIR) begin
          state_d = S_RDAT;
        end else if (timeout_hit) begin
          go_abort = 1'b1;
        end
      end
      S_RDAT: begin
        // Held in rbuf so rdata only changes once the read actually completes
        if (bus.DIR) begin
          rbuf_d  = bus.DATA_in;
          state_d = S_RTB;
        end else begin
          go_abort = 1'b1;
        end
      end
      S_RTB: begin
        if (!bus.DIR) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          rdata_d = rbuf_q;
        end else if (timeout_hit) begin
          go_abort = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        data_oe_d = 1'b0;
      end
    endcase

    if (go_abort) begin
      state_d    = S_IDLE;
      data_oe_d  = 1'b0;
      data_out_d = '0;
      stp_d      = 1'b0;
      abort_d    = 1'b1;
    end

    if (in_timed_state && (state_d == state_q)) begin
      timer_d = timer_q + 8'd1;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.abort    = abort_q;
  assign bus.rdata    = rdata_q;
  assign bus.DATA_out = data_out_q;
  assign bus.DATA_oe  = data_oe_q;
  assign bus.STP      = stp_q;

endmodule
`default_nettype wire

// File: tb/tb_ulpi_reg_access.sv
`default_nettype none
// ============================================================================
// tb_ulpi_reg_access : PHY-side stimulus and checking for ulpi_reg_access
// Revision: 1.0
// ============================================================================
module tb_ulpi_reg_access;

  localparam int TMO = 8;

  logic clk_ext = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] model_rdata;

  ulpi_reg_access_if u_if ();

  ulpi_reg_access #(.NXT_TIMEOUT(TMO)) dut (
    .clk_ext (clk_ext),
    .rst     (rst),
    .bus     (u_if)
  );

  always #5 clk_ext = ~clk_ext;

  // Inputs change and outputs are observed on the falling edge
  task automatic tick();
    @(negedge clk_ext);
  endtask

  task automatic run_write(input logic [5:0] a, input logic [7:0] d,
                           input int cs, input int ws, input int hold);
    logic [7:0] cmd;
    cmd = {2'b10, a};
    tick();
    u_if.req = 1'b1; u_if.rw = 1'b0; u_if.addr = a; u_if.wdata = d;
    u_if.NXT = 1'b0; u_if.DIR = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      u_if.req = 1'b0;
      checks++;
      if ({u_if.busy, u_if.DATA_oe, u_if.abort} !== 3'b100) begin
        failures++;
        $display("FAIL wait_bus busy/oe/abort=%b%b%b want 100", u_if.busy, u_if.DATA_oe, u_if.abort);
      end
      if (h == hold - 1) u_if.DIR = 1'b0;
    end
    for (int i = 0; i <= cs; i++) begin
      tick();
      u_if.req = 1'b0; u_if.rw = 1'b1; u_if.addr = ~a; u_if.wdata = ~d;
      checks++;
      if ({u_if.busy, u_if.DATA_oe, u_if.STP, u_if.done, u_if.abort, u_if.DATA_out} !== {5'b11000, cmd}) begin
        failures++;
        $display("FAIL wr_cmd busy/oe/stp/done/abort=%b%b%b%b%b data=%h want 11000 %h",
                 u_if.busy, u_if.DATA_oe, u_if.STP, u_if.done, u_if.abort, u_if.DATA_out, cmd);
      end
      u_if.NXT = (i == cs);
    end
    for (int i = 0; i <= ws; i++) begin
      tick();
      checks++;
      if ({u_if.busy, u_if.DATA_oe, u_if.STP, u_if.done, u_if.abort, u_if.DATA_out} !== {5'b11000, d}) begin
        failures++;
        $display("FAIL wr_data busy/oe/stp/done/abort=%b%b%b%b%b data=%h want 11000 %h",
                 u_if.busy, u_if.DATA_oe, u_if.STP, u_if.done, u_if.abort, u_if.DATA_out, d);
      end
      u_if.NXT = (i == ws);
    end
    tick();
    u_if.NXT = 1'b0;
    checks++;
    if ({u_if.DATA_oe, u_if.STP, u_if.done, u_if.DATA_out} !== {3'b110, 8'h00}) begin
      failures++;
      $display("FAIL wr_stop oe/stp/done=%b%b%b data=%h want 110 00", u_if.DATA_oe, u_if.STP, u_if.done, u_if.DATA_out);
    end
    tick();
    checks++;
    if ({u_if.done, u_if.abort, u_if.DATA_oe, u_if.STP, u_if.busy, u_if.rdata} !== {5'b10001, model_rdata}) begin
      failures++;
      $display("FAIL wr_done done/abort/oe/stp/busy=%b%b%b%b%b rdata=%h want 10001 %h",
               u_if.done, u_if.abort, u_if.DATA_oe, u_if.STP, u_if.busy, u_if.rdata, model_rdata);
    end
    tick();
    checks++;
    if ({u_if.busy, u_if.done, u_if.DATA_oe} !== 3'b000) begin
      failures++;
      $display("FAIL wr_idle busy/done/oe=%b%b%b want 000", u_if.busy, u_if.done, u_if.DATA_oe);
    end
  endtask

  task automatic run_read(input logic [5:0] a, input logic [7:0] rd,
                          input int cs, input int ta, input int rb);
    logic [7:0] cmd;
    cmd = {2'b11, a};
    tick();
    u_if.req = 1'b1; u_if.rw = 1'b1; u_if.addr = a; u_if.DIR = 1'b0; u_if.NXT = 1'b0;
    for (int i = 0; i <= cs; i++) begin
      tick();
      u_if.req = 1'b0; u_if.rw = 1'b0; u_if.addr = ~a;
      checks++;
      if ({u_if.busy, u_if.DATA_oe, u_if.done, u_if.DATA_out} !== {3'b110, cmd}) begin
        failures++;
        $display("FAIL rd_cmd busy/oe/done=%b%b%b data=%h want 110 %h", u_if.busy, u_if.DATA_oe, u_if.done, u_if.DATA_out, cmd);
      end
      u_if.NXT = (i == cs);
    end
    for (int j = 0; j <= ta; j++) begin
      tick();
      u_if.NXT = 1'b0;
      checks++;
      if ({u_if.DATA_oe, u_if.done, u_if.abort, u_if.busy} !== 4'b0001) begin
        failures++;
        $display("FAIL rd_turn oe/done/abort/busy=%b%b%b%b want 0001", u_if.DATA_oe, u_if.done, u_if.abort, u_if.busy);
      end
      u_if.DIR = (j == ta);
    end
    tick();
    u_if.DATA_in = rd;
    checks++;
    if ({u_if.DATA_oe, u_if.done, u_if.abort, u_if.busy} !== 4'b0001) begin
      failures++;
      $display("FAIL rd_data oe/done/abort/busy=%b%b%b%b want 0001", u_if.DATA_oe, u_if.done, u_if.abort, u_if.busy);
    end
    for (int k = 0; k <= rb; k++) begin
      tick();
      u_if.DATA_in = 8'($urandom);
      checks++;
      if ({u_if.DATA_oe, u_if.done, u_if.abort, u_if.busy, u_if.rdata} !== {4'b0001, model_rdata}) begin
        failures++;
        $display("FAIL rd_tb oe/done/abort/busy=%b%b%b%b rdata=%h want 0001 %h",
                 u_if.DATA_oe, u_if.done, u_if.abort, u_if.busy, u_if.rdata, model_rdata);
      end
      u_if.DIR = (k != rb);
    end
    tick();
    model_rdata = rd;
    checks++;
    if ({u_if.done, u_if.abort, u_if.DATA_oe, u_if.busy, u_if.rdata} !== {4'b1001, model_rdata}) begin
      failures++;
      $display("FAIL rd_done done/abort/oe/busy=%b%b%b%b rdata=%h want 1001 %h",
               u_if.done, u_if.abort, u_if.DATA_oe, u_if.busy, u_if.rdata, model_rdata);
    end
    tick();
    checks++;
    if ({u_if.busy, u_if.done} !== 2'b00) begin
      failures++;
      $display("FAIL rd_idle busy/done=%b%b want 00", u_if.busy, u_if.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({u_if.busy, u_if.done, u_if.abort, u_if.rdata, u_if.DATA_out, u_if.DATA_oe, u_if.STP} !== 20'd0) begin
      failures++;
      $display("FAIL reset_outputs got %h want 0",
               {u_if.busy, u_if.done, u_if.abort, u_if.rdata, u_if.DATA_out, u_if.DATA_oe, u_if.STP});
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({u_if.busy, u_if.DATA_oe, u_if.STP} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release busy/oe/stp=%b%b%b want 000", u_if.busy, u_if.DATA_oe, u_if.STP);
    end
  endtask

  task automatic test_write();
    run_write(6'h0A, 8'h45, 0, 0, 0);
    for (int n = 0; n < 6; n++)
      run_write(6'($urandom), 8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 0);
  endtask

  task automatic test_read();
    run_read(6'h16, 8'hA5, 0, 0, 0);
    for (int n = 0; n < 6; n++) begin
      run_read(6'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      run_write(6'($urandom), 8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
    end
  endtask

  task automatic test_throttle();
    run_write(6'h2C, 8'h3E, 5, 3, 0);
  endtask

  task automatic test_takeover();
    tick();
    u_if.req = 1'b1; u_if.rw = 1'b0; u_if.addr = 6'h05; u_if.wdata = 8'hC3;
    u_if.DIR = 1'b0; u_if.NXT = 1'b0;
    tick();
    u_if.req = 1'b0; u_if.NXT = 1'b1;
    tick();
    u_if.NXT = 1'b0; u_if.DIR = 1'b1;
    checks++;
    if ({u_if.DATA_oe, u_if.DATA_out} !== {1'b1, 8'hC3}) begin
      failures++;
      $display("FAIL tko_wdat oe=%b data=%h want 1 c3", u_if.DATA_oe, u_if.DATA_out);
    end
    tick();
    checks++;
    if ({u_if.DATA_oe, u_if.abort, u_if.done, u_if.STP, u_if.busy, u_if.rdata} !== {5'b01001, model_rdata}) begin
      failures++;
      $display("FAIL tko_abort oe/abort/done/stp/busy=%b%b%b%b%b rdata=%h want 01001 %h",
               u_if.DATA_oe, u_if.abort, u_if.done, u_if.STP, u_if.busy, u_if.rdata, model_rdata);
    end
    tick();
    u_if.DIR = 1'b0;
    checks++;
    if ({u_if.busy, u_if.abort, u_if.STP, u_if.done} !== 4'b0000) begin
      failures++;
      $display("FAIL tko_idle busy/abort/stp/done=%b%b%b%b want 0000", u_if.busy, u_if.abort, u_if.STP, u_if.done);
    end
  endtask

  task automatic test_timeout();
    tick();
    u_if.req = 1'b1; u_if.rw = 1'b0; u_if.addr = 6'h11; u_if.wdata = 8'h99;
    u_if.DIR = 1'b0; u_if.NXT = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      tick();
      // a req at i==2 arrives while busy and must be dropped
      u_if.req = (i == 2); u_if.rw = 1'b1; u_if.addr = 6'h22;
      checks++;
      if ({u_if.DATA_oe, u_if.abort, u_if.busy, u_if.DATA_out} !== {3'b101, 8'h91}) begin
        failures++;
        $display("FAIL tmo_cmd cyc=%0d oe/abort/busy=%b%b%b data=%h want 101 91",
                 i, u_if.DATA_oe, u_if.abort, u_if.busy, u_if.DATA_out);
      end
    end
    tick();
    u_if.req = 1'b0;
    checks++;
    if ({u_if.abort, u_if.done, u_if.DATA_oe, u_if.STP} !== 4'b1000) begin
      failures++;
      $display("FAIL tmo_abort abort/done/oe/stp=%b%b%b%b want 1000", u_if.abort, u_if.done, u_if.DATA_oe, u_if.STP);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({u_if.busy, u_if.DATA_oe, u_if.abort, u_if.done} !== 4'b0000) begin
        failures++;
        $display("FAIL tmo_ignored cyc=%0d busy/oe/abort/done=%b%b%b%b want 0000",
                 i, u_if.busy, u_if.DATA_oe, u_if.abort, u_if.done);
      end
    end
    run_write(6'h3F, 8'($urandom), 0, 1, 20);
  endtask

  task automatic test_reset_mid();
    tick();
    u_if.req = 1'b1; u_if.rw = 1'b1; u_if.addr = 6'h16; u_if.DIR = 1'b0; u_if.NXT = 1'b0;
    tick();
    u_if.req = 1'b0; u_if.NXT = 1'b1;
    tick();
    u_if.NXT = 1'b0; u_if.DIR = 1'b1;
    tick();
    u_if.DATA_in = 8'h5A;
    tick();
    checks++;
    if ({u_if.busy, u_if.DATA_oe, u_if.done} !== 3'b100) begin
      failures++;
      $display("FAIL rstmid_rtb busy/oe/done=%b%b%b want 100", u_if.busy, u_if.DATA_oe, u_if.done);
    end
    #2 rst = 1'b1;
    #1;
    model_rdata = 8'h00;
    checks++;
    if ({u_if.busy, u_if.done, u_if.abort, u_if.rdata, u_if.DATA_out, u_if.DATA_oe, u_if.STP} !== 20'd0) begin
      failures++;
      $display("FAIL rstmid_async got %h want 0",
               {u_if.busy, u_if.done, u_if.abort, u_if.rdata, u_if.DATA_out, u_if.DATA_oe, u_if.STP});
    end
    tick();
    u_if.DIR = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if ({u_if.busy, u_if.done, u_if.abort, u_if.DATA_oe} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_after busy/done/abort/oe=%b%b%b%b want 0000", u_if.busy, u_if.done, u_if.abort, u_if.DATA_oe);
    end
    run_write(6'h0A, 8'h45, 0, 0, 0);
  endtask

  initial begin
    rst          = 1'b1;
    u_if.req     = 1'b0;
    u_if.rw      = 1'b0;
    u_if.addr    = '0;
    u_if.wdata   = '0;
    u_if.DIR     = 1'b0;
    u_if.NXT     = 1'b0;
    u_if.DATA_in = '0;
    model_rdata  = 8'h00;

    test_reset();
    test_write();
    test_read();
    test_throttle();
    test_takeover();
    test_timeout();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
